// File: rtl/flappy_pkg.sv
// flappy_pkg: FSM encoding and default timing constants shared with the action stage
package flappy_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, WINDOW = 2'b01, DONE = 2'b10} state_t;
  localparam int CR_DEF = 14;
  localparam int DEB_W_DEF = 4;
  localparam int DEB_CNT_DEF = 10;
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: enable/done handshake with move decisions plus raw button lines
interface button_conditioner_if;
  logic e_inp_i;
  logic up_raw_i;
  logic down_raw_i;
  logic up_o;
  logic down_o;
  logic d_inp_o;
  modport master (output e_inp_i, up_raw_i, down_raw_i, input up_o, down_o, d_inp_o);
  modport slave (input e_inp_i, up_raw_i, down_raw_i, output up_o, down_o, d_inp_o);
endinterface

// File: rtl/debounce_cell.sv
// debounce_cell: 2-FF synchroniser, stable-count debounce and registered rising-edge pulse
module debounce_cell #(
  parameter int DEB_W = 4,
  parameter int DEB_CNT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  logic s1, s2, hit;
  logic [DEB_W-1:0] cnt;
  assign hit = (s2 != level) && (cnt == DEB_W'(DEB_CNT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 != level && !hit) ? cnt + 1'b1 : '0;
      level <= hit ? s2 : level;
      rise <= hit & s2;
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces up/down buttons, latches presses, hands one move per frame.
// Define HOLD_REPEAT_EN to let a button still held at capture count as a press every frame.
module button_conditioner
  import flappy_pkg::*;
#(
  parameter int CR = CR_DEF,
  parameter int DEB_W = DEB_W_DEF,
  parameter int DEB_CNT = DEB_CNT_DEF
) (
  input logic clk_i,
  input logic rst_i,
  button_conditioner_if.slave bus
);
`ifdef HOLD_REPEAT_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif
  state_t state, state_n;
  logic [CR-1:0] tick, tick_n;
  logic pend_up, pend_dn, pend_up_n, pend_dn_n;
  logic up, dn, up_n, dn_n;
  logic lvl_up, lvl_dn, rise_up, rise_dn, cap_up, cap_dn;
  debounce_cell #(.DEB_W(DEB_W), .DEB_CNT(DEB_CNT)) u_up (
    .clk(clk_i), .rst(rst_i), .raw(bus.up_raw_i), .level(lvl_up), .rise(rise_up)
  );
  debounce_cell #(.DEB_W(DEB_W), .DEB_CNT(DEB_CNT)) u_dn (
    .clk(clk_i), .rst(rst_i), .raw(bus.down_raw_i), .level(lvl_dn), .rise(rise_dn)
  );
  assign cap_up = pend_up | (HOLD & lvl_up);
  assign cap_dn = pend_dn | (HOLD & lvl_dn);
  // a rise arriving in the capture cycle survives the clear and belongs to the next window
  always_comb begin
    state_n = state;
    tick_n = '0;
    up_n = up;
    dn_n = dn;
    pend_up_n = pend_up | rise_up;
    pend_dn_n = pend_dn | rise_dn;
    case (state)
      IDLE: state_n = bus.e_inp_i ? WINDOW : IDLE;
      WINDOW:
        if (!bus.e_inp_i) state_n = IDLE;
        else if (tick == '1) begin
          state_n = DONE;
          up_n = cap_up & ~cap_dn;
          dn_n = cap_dn & ~cap_up;
          pend_up_n = rise_up;
          pend_dn_n = rise_dn;
        end else tick_n = tick + 1'b1;
      DONE:
        if (!bus.e_inp_i) begin
          state_n = IDLE;
          up_n = 1'b0;
          dn_n = 1'b0;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      tick <= '0;
      pend_up <= 1'b0;
      pend_dn <= 1'b0;
      up <= 1'b0;
      dn <= 1'b0;
    end else begin
      state <= state_n;
      tick <= tick_n;
      pend_up <= pend_up_n;
      pend_dn <= pend_dn_n;
      up <= up_n;
      dn <= dn_n;
    end
  assign bus.up_o = up;
  assign bus.down_o = dn;
  assign bus.d_inp_o = (state == DONE);
endmodule
